// File: rtl/pwm_pkg.sv
// Shared widths, duty types and the register-word unpacker for the robot PWM driver.
package pwm_pkg;

    localparam int NUM_CH = 4;
    localparam int DUTY_W = 8;
    localparam int WORD_W = NUM_CH * DUTY_W;

    typedef logic [DUTY_W-1:0] duty_t;
    typedef duty_t [NUM_CH-1:0] duty_arr_t;

    // Byte i of the CPU word is the duty of channel i.
    function automatic duty_arr_t unpack_word(input logic [WORD_W-1:0] word);
        duty_arr_t duties;
        for (int i = 0; i < NUM_CH; i++) begin
            duties[i] = word[i*DUTY_W +: DUTY_W];
        end
        return duties;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler plus period counter running 0..PERIOD-1.
// Flags the wrapping tick and the first clock of every period.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int PERIOD   = 255
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              i_en,
    output logic              o_wrap,
    output logic              o_start,
    output logic [DUTY_W-1:0] o_cnt
);

    localparam int                PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);

    logic [PS_W-1:0]   r_presc;
    logic [DUTY_W-1:0] r_cnt;
    logic              w_tick;

    assign w_tick  = i_en && (r_presc == PS_LAST);
    assign o_wrap  = w_tick && (r_cnt == CNT_LAST);
    // Prescaler and counter are both zero exactly once per period while running.
    assign o_start = i_en && (r_presc == '0) && (r_cnt == '0);
    assign o_cnt   = r_cnt;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else if (!i_en) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else if (w_tick) begin
            // NOTE: non-blocking so the wrap test above sees the pre-edge count.
            r_presc <= '0;
            r_cnt   <= o_wrap ? '0 : r_cnt + DUTY_W'(1);
        end else begin
            r_presc <= r_presc + PS_W'(1);
        end
    end

endmodule

// File: rtl/pwm_robot_driver.sv
// Four-channel PWM driver for the robot motor/servo pins, fed by the CPU PWM word.
// Duties are double-buffered and only change at period boundaries.
module pwm_robot_driver
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int PERIOD   = 255
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [WORD_W-1:0] pwm_word,
    input  logic              en,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start,
    output logic [DUTY_W-1:0] cnt_dbg
);

    logic              r_en_q;
    logic              w_run;
    logic              w_wrap;
    logic              w_start;
    logic [DUTY_W-1:0] w_cnt;
    duty_arr_t         r_shadow;
    logic [NUM_CH-1:0] w_cmp;
    logic [NUM_CH-1:0] r_pwm_out;
    logic              r_period_start;

    // The first edge after reset or after en rises acts as a disabled edge, so the
    // shadow captures the live word before the first period starts.
    assign w_run = en & r_en_q;

    pwm_timebase #(
        .PRESCALE (PRESCALE),
        .PERIOD   (PERIOD)
    ) u_timebase (
        .clk     (clk),
        .nRst    (nRst),
        .i_en    (w_run),
        .o_wrap  (w_wrap),
        .o_start (w_start),
        .o_cnt   (w_cnt)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_en_q   <= 1'b0;
            // NOTE: the shadow bank is reset like any flop; it is tiny and its value gates the pins.
            r_shadow <= '0;
        end else begin
            r_en_q <= en;
            if (!w_run || w_wrap) begin
                r_shadow <= unpack_word(pwm_word);
            end
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves w_cmp unassigned and no latch is inferred.
        w_cmp = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cmp[i] = ({1'b0, w_cnt} < {1'b0, r_shadow[i]});
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_pwm_out      <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_pwm_out      <= w_run ? w_cmp : '0;
            r_period_start <= w_start;
        end
    end

    assign pwm_out      = r_pwm_out;
    assign period_start = r_period_start;
    assign cnt_dbg      = w_cnt;

endmodule
